// File: rtl/ray_sched_pkg.sv
// Shared types for the ray scheduler.
//   FP_W / VEC3_W   : fixed-point scalar and 3-vector widths used on the ray unit interface
//   PIX_COORD_W     : width of the output pixel column/row tags
//   sched_state_t   : frame controller states
//   pix_result_t    : one ray result as stored in the result FIFO
package ray_sched_pkg;

  localparam int unsigned FP_W        = 32;
  localparam int unsigned VEC3_W      = 3 * FP_W;
  localparam int unsigned PIX_COORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [VEC3_W-1:0] point;
    logic              hit;
  } pix_result_t;

endpackage

// File: rtl/ray_result_fifo.sv
// Show-ahead result FIFO between the ray unit and the framebuffer writer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   wr_i         : push wr_data_i (a write while full is only legal with a read)
//   rd_i         : pop the head entry; ignored when empty
//   empty_o      : FIFO holds no entries
//   rd_data_o    : head entry, valid whenever !empty_o
// DEPTH must be a power of two, at least 2.
module ray_result_fifo
  import ray_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_i,
  input  pix_result_t wr_data_i,
  input  logic        rd_i,
  output logic        empty_o,
  output pix_result_t rd_data_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  pix_result_t       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              full;
  logic              rd_en;
  logic              wr_en;

  assign empty_o   = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign rd_en     = rd_i && !empty_o;
  assign wr_en     = wr_i && (!full || rd_en);
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage is reset so the head payload reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Credits upstream bound occupancy; a push into a full FIFO without a pop is a bug.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(wr_i && full && !rd_en));
    end
  end

endmodule

// File: rtl/ray_scheduler.sv
// Frame-level ray scheduler: sweeps an H_RES x V_RES grid issuing one screen
// coordinate per cycle to the ray unit under an in-flight credit limit, then
// streams the in-order results to a valid/ready framebuffer writer.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   start                          : begin a frame when idle
//   x_start, y_start, x_step, y_step : grid origin and increments, latched on start
//   busy, frame_done               : frame in progress / one-cycle completion pulse
//   ru_valid_in, ru_screen_x/y     : ray issue to the ray unit
//   ru_valid_out, ru_point, ru_hit : in-order ray results
//   pix_valid, pix_ready, pix_x, pix_y, pix_point, pix_hit : pixel output stream
// Build option RAY_SCHED_PERF_EN adds perf_cycles (busy cycles) and perf_stall
// (ISSUE cycles blocked by credits), both cleared on an accepted start.
module ray_scheduler
  import ray_sched_pkg::*;
#(
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned MAX_INFLIGHT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [FP_W-1:0]        x_start,
  input  logic [FP_W-1:0]        y_start,
  input  logic [FP_W-1:0]        x_step,
  input  logic [FP_W-1:0]        y_step,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   ru_valid_in,
  output logic [FP_W-1:0]        ru_screen_x,
  output logic [FP_W-1:0]        ru_screen_y,
  input  logic                   ru_valid_out,
  input  logic [VEC3_W-1:0]      ru_point,
  input  logic                   ru_hit,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [PIX_COORD_W-1:0] pix_x,
  output logic [PIX_COORD_W-1:0] pix_y,
  output logic [VEC3_W-1:0]      pix_point,
  output logic                   pix_hit
`ifdef RAY_SCHED_PERF_EN
  ,
  output logic [31:0]            perf_cycles,
  output logic [31:0]            perf_stall
`endif
);

  localparam int unsigned IW = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [PIX_COORD_W-1:0] COL_LAST = PIX_COORD_W'(H_RES - 1);
  localparam logic [PIX_COORD_W-1:0] ROW_LAST = PIX_COORD_W'(V_RES - 1);

  sched_state_t           state_q, state_d;
  logic [FP_W-1:0]        x0_q, x0_d, dx_q, dx_d, dy_q, dy_d;
  logic [FP_W-1:0]        cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [PIX_COORD_W-1:0] col_q, col_d, row_q, row_d;
  logic [PIX_COORD_W-1:0] rcol_q, rcol_d, rrow_q, rrow_d;
  logic [IW-1:0]          inflight_q, inflight_d;
  logic                   issue_q, issue_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  pix_result_t            fifo_wdata, fifo_rdata;
  logic                   fifo_empty;
  logic                   pix_fire;

  assign fifo_wdata.point = ru_point;
  assign fifo_wdata.hit   = ru_hit;
  assign pix_valid        = !fifo_empty;
  assign pix_fire         = pix_valid && pix_ready;

  ray_result_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_i      (ru_valid_out),
    .wr_data_i (fifo_wdata),
    .rd_i      (pix_ready),
    .empty_o   (fifo_empty),
    .rd_data_o (fifo_rdata)
  );

  // Next-state: issue/result counters, credits and frame FSM.
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    col_d      = col_q;
    row_d      = row_q;
    rcol_d     = rcol_q;
    rrow_d     = rrow_q;
    inflight_d = inflight_q + IW'(issue_q) - IW'(pix_fire);

    // issue_q is the ray presented this cycle; advance to the next grid point.
    if (issue_q) begin
      if (col_q == COL_LAST) begin
        col_d   = '0;
        cur_x_d = x0_q;
        cur_y_d = cur_y_q + dy_q;
        row_d   = (row_q == ROW_LAST) ? '0 : row_q + PIX_COORD_W'(1);
      end else begin
        col_d   = col_q + PIX_COORD_W'(1);
        cur_x_d = cur_x_q + dx_q;
      end
    end

    if (pix_fire) begin
      if (rcol_q == COL_LAST) begin
        rcol_d = '0;
        rrow_d = (rrow_q == ROW_LAST) ? '0 : rrow_q + PIX_COORD_W'(1);
      end else begin
        rcol_d = rcol_q + PIX_COORD_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ISSUE;
          x0_d       = x_start;
          dx_d       = x_step;
          dy_d       = y_step;
          cur_x_d    = x_start;
          cur_y_d    = y_start;
          col_d      = '0;
          row_d      = '0;
          rcol_d     = '0;
          rrow_d     = '0;
          inflight_d = '0;
        end
      end
      ST_ISSUE: begin
        if (issue_q && (col_q == COL_LAST) && (row_q == ROW_LAST)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered issue strobe: decided from next cycle's state and credits.
    issue_d = (state_d == ST_ISSUE) && (inflight_d < IW'(MAX_INFLIGHT));
    busy_d  = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      x0_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      rcol_q     <= '0;
      rrow_q     <= '0;
      inflight_q <= '0;
      issue_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rcol_q     <= rcol_d;
      rrow_q     <= rrow_d;
      inflight_q <= inflight_d;
      issue_q    <= issue_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign ru_valid_in = issue_q;
  assign ru_screen_x = cur_x_q;
  assign ru_screen_y = cur_y_q;
  assign pix_x       = rcol_q;
  assign pix_y       = rrow_q;
  assign pix_point   = fifo_rdata.point;
  assign pix_hit     = fifo_rdata.hit;

`ifdef RAY_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // In ISSUE a cycle without an issue strobe can only be a credit stall.
  always_comb begin
    perf_cycles_d = perf_cycles_q + 32'(busy_q);
    perf_stall_d  = perf_stall_q + 32'((state_q == ST_ISSUE) && !issue_q);
    if ((state_q == ST_IDLE) && start) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_ray_scheduler.sv
// Self-checking bench for ray_scheduler on a small 4x2 grid with 4 credits.
// A behavioural in-order ray unit with random latency answers each issue; the
// expected issue and pixel streams are computed directly from the grid origin,
// steps and raster index.
module tb_ray_scheduler;
  import ray_sched_pkg::*;

  localparam int unsigned H    = 4;
  localparam int unsigned V    = 2;
  localparam int unsigned MAXF = 4;
  localparam int unsigned NPIX = H * V;
  localparam logic [FP_W-1:0] ONE = 32'h0001_0000;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   start = 1'b0;
  logic [FP_W-1:0]        x_start = '0, y_start = '0, x_step = '0, y_step = '0;
  logic                   busy, frame_done, ru_valid_in;
  logic [FP_W-1:0]        ru_screen_x, ru_screen_y;
  logic                   ru_valid_out = 1'b0;
  logic [VEC3_W-1:0]      ru_point = '0;
  logic                   ru_hit = 1'b0;
  logic                   pix_valid;
  logic                   pix_ready = 1'b0;
  logic [PIX_COORD_W-1:0] pix_x, pix_y;
  logic [VEC3_W-1:0]      pix_point;
  logic                   pix_hit;
`ifdef RAY_SCHED_PERF_EN
  logic [31:0]            perf_cycles, perf_stall;
`endif

  always #5 clk = ~clk;

  ray_scheduler #(
    .H_RES        (H),
    .V_RES        (V),
    .MAX_INFLIGHT (MAXF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .x_start      (x_start),
    .y_start      (y_start),
    .x_step       (x_step),
    .y_step       (y_step),
    .busy         (busy),
    .frame_done   (frame_done),
    .ru_valid_in  (ru_valid_in),
    .ru_screen_x  (ru_screen_x),
    .ru_screen_y  (ru_screen_y),
    .ru_valid_out (ru_valid_out),
    .ru_point     (ru_point),
    .ru_hit       (ru_hit),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_point    (pix_point),
    .pix_hit      (pix_hit)
`ifdef RAY_SCHED_PERF_EN
    ,
    .perf_cycles  (perf_cycles),
    .perf_stall   (perf_stall)
`endif
  );

  typedef struct {
    int              due;
    logic [FP_W-1:0] x;
    logic [FP_W-1:0] y;
  } ray_t;

  ray_t            rq[$];
  int              n_cmp = 0, n_err = 0;
  int              cyc = 0, last_due = 0;
  int              n_issued = 0, n_acc = 0, n_done = 0, busy_cnt = 0;
  int              ready_pct = 100, ready_hold_until = 0, lat_lo = 1, lat_hi = 1;
  int              start_cyc = 0;
  logic            start_req = 1'b0, last_busy = 1'b0, last_issue = 1'b0;
  logic            perf_nostall = 1'b0;
  logic [FP_W-1:0] fxs = '0, fys = '0, fdx = '0, fdy = '0;
  logic [FP_W-1:0] st_x = '0, st_y = '0, st_dx = '0, st_dy = '0;
  logic            hold_v = 1'b0;
  logic [127:0]    held = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Grid point n of an axis: origin plus n steps, modulo the fp width.
  function automatic logic [FP_W-1:0] axis(input logic [FP_W-1:0] base,
                                           input logic [FP_W-1:0] step, input int n);
    logic [FP_W-1:0] r;
    r = base + step * FP_W'(n);
    return r;
  endfunction

  // One clock: drive inputs for this cycle, then observe and score the DUT.
  task automatic tick();
    ray_t            r;
    int              k, col, row, lat, inflight_before;
    logic [FP_W-1:0] ex, ey;
    @(negedge clk);
    cyc++;
    inflight_before = n_issued - n_acc;

    if (start_req) begin
      start = 1'b1;
      x_start = st_x; y_start = st_y; x_step = st_dx; y_step = st_dy;
      start_cyc = cyc;
      start_req = 1'b0;
    end else begin
      start = 1'b0;
      x_start = $urandom; y_start = $urandom; x_step = $urandom; y_step = $urandom;
    end

    ru_valid_out = 1'b0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      r = rq.pop_front();
      ru_valid_out = 1'b1;
      ru_point = {r.x, r.y, r.x ^ r.y};
      ru_hit   = r.x[16] ^ r.y[16];
    end

    pix_ready = (cyc < ready_hold_until) ? 1'b0 : ($urandom_range(99, 0) < 32'(ready_pct));

    if (hold_v && pix_valid) chk("hold_payload", {15'd0, pix_x, pix_y, pix_point, pix_hit}, held);
    hold_v = pix_valid && !pix_ready;
    held   = {15'd0, pix_x, pix_y, pix_point, pix_hit};

    if (pix_valid && pix_ready) begin
      k   = n_acc % NPIX;
      col = k % H;
      row = k / H;
      ex  = axis(fxs, fdx, col);
      ey  = axis(fys, fdy, row);
      chk("pix_x", 128'(pix_x), 128'(col));
      chk("pix_y", 128'(pix_y), 128'(row));
      chk("pix_point", 128'(pix_point), 128'({ex, ey, ex ^ ey}));
      chk("pix_hit", 128'(pix_hit), 128'(ex[16] ^ ey[16]));
      n_acc++;
    end

    last_issue = ru_valid_in;
    if (ru_valid_in) begin
      k   = n_issued % NPIX;
      ex  = axis(fxs, fdx, k % H);
      ey  = axis(fys, fdy, k / H);
      chk("ru_x", 128'(ru_screen_x), 128'(ex));
      chk("ru_y", 128'(ru_screen_y), 128'(ey));
      chk("credit", 128'(inflight_before < int'(MAXF)), 128'(1));
      if (n_issued == 0) chk("first_issue_lat", 128'(cyc), 128'(start_cyc + 1));
      n_issued++;
      lat = $urandom_range(lat_hi, lat_lo);
      r.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      r.x = ru_screen_x;
      r.y = ru_screen_y;
      last_due = r.due;
      rq.push_back(r);
    end

    if (busy) busy_cnt++;
    if (frame_done) begin
      n_done++;
      chk("busy_at_done", 128'(busy), 128'(0));
      chk("busy_before_done", 128'(last_busy), 128'(1));
`ifdef RAY_SCHED_PERF_EN
      chk("perf_cycles", 128'(perf_cycles), 128'(busy_cnt));
      if (perf_nostall) chk("perf_stall", 128'(perf_stall), 128'(0));
`endif
    end
    last_busy = busy;
  endtask

  task automatic frame_setup(input logic [FP_W-1:0] xs, input logic [FP_W-1:0] ys,
                             input logic [FP_W-1:0] dx, input logic [FP_W-1:0] dy);
    fxs = xs; fys = ys; fdx = dx; fdy = dy;
    st_x = xs; st_y = ys; st_dx = dx; st_dy = dy;
    n_issued = 0; n_acc = 0; n_done = 0; busy_cnt = 0;
    start_req = 1'b1;
  endtask

  task automatic run_frame(input logic [FP_W-1:0] xs, input logic [FP_W-1:0] ys,
                           input logic [FP_W-1:0] dx, input logic [FP_W-1:0] dy,
                           input int rpct, input int llo, input int lhi,
                           input int hold, input bit mid_start);
    int budget;
    bit mid_fired, stall_checked;
    frame_setup(xs, ys, dx, dy);
    ready_pct = rpct; lat_lo = llo; lat_hi = lhi;
    ready_hold_until = cyc + 1 + hold;
    budget = 3000; mid_fired = 0; stall_checked = 0;
    while (n_done == 0 && budget > 0) begin
      tick();
      budget--;
      if (mid_start && !mid_fired && n_issued == 3) begin
        mid_fired = 1;
        st_x = $urandom; st_y = $urandom; st_dx = $urandom; st_dy = $urandom;
        start_req = 1'b1;
      end
      if (hold > 0 && !stall_checked && cyc == ready_hold_until - 1) begin
        stall_checked = 1;
        chk("stall_issues", 128'(n_issued), 128'(MAXF));
        chk("stall_inflight", 128'(n_issued - n_acc), 128'(MAXF));
        tick();
        chk("stall_last_blocked", 128'(last_issue), 128'(0));
        tick();
        chk("resume_next_cycle", 128'(last_issue), 128'(1));
        budget -= 2;
      end
    end
    chk("frame_done_seen", 128'(n_done), 128'(1));
    chk("issue_count", 128'(n_issued), 128'(NPIX));
    chk("pixel_count", 128'(n_acc), 128'(NPIX));
    repeat (12) tick();
    chk("single_done", 128'(n_done), 128'(1));
    chk("no_extra_issue", 128'(n_issued), 128'(NPIX));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_outs"}, 128'({busy, frame_done, ru_valid_in, pix_valid, pix_hit}), 128'(0));
    chk({tag, "_coord"}, 128'({ru_screen_x, ru_screen_y, pix_x, pix_y}), 128'(0));
    chk({tag, "_point"}, 128'(pix_point), 128'(0));
  endtask

  initial begin
    int budget;
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_no_issue", 128'(n_issued), 128'(0));

    // Unit steps, fixed latency 5, writer always ready.
    run_frame('0, '0, ONE, ONE, 100, 5, 5, 0, 1'b0);
    // Writer held off: credits cap issue, then release.
    run_frame(ONE, 32'h0002_0000, ONE, ONE, 100, 3, 6, 40, 1'b0);
    // Start pulse mid-frame must be ignored.
    run_frame($urandom, $urandom, $urandom, $urandom, 30, 3, 40, 0, 1'b1);
    // Random frames: 30% ready, latency 3..40.
    for (int f = 0; f < 6; f++) begin
      run_frame($urandom, $urandom, $urandom, $urandom, 30, 3, 40, 0, 1'b0);
    end

    // Reset in the middle of ISSUE with rays outstanding.
    frame_setup('0, '0, ONE, ONE);
    ready_hold_until = cyc + 1000; lat_lo = 30; lat_hi = 40;
    budget = 50;
    while (n_issued < 3 && budget > 0) begin
      tick();
      budget--;
    end
    chk("rst_pre_issues", 128'(n_issued), 128'(3));
    rst_n = 1'b0;
    #1 chk_outputs_zero("midrst");
    rq.delete();
    last_due = 0;
    ru_valid_out = 1'b0;
    hold_v = 1'b0;
    n_issued = 0; n_acc = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    ready_hold_until = 0;
    repeat (6) tick();
    chk("post_rst_no_issue", 128'(n_issued), 128'(0));
    chk("post_rst_idle", 128'(busy), 128'(0));
    run_frame(ONE, ONE, ONE, ONE, 50, 3, 12, 0, 1'b0);

    // Short latency and always-ready writer: credits never limit.
    perf_nostall = 1'b1;
    run_frame('0, '0, ONE, ONE, 100, 1, 1, 0, 1'b0);
    perf_nostall = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
